// File: rtl/overcooked_pkg.sv
// Shared constants and pot state type for the Overcooked stove/onion logic.
// Both the pot controller and the onion tracker import this.
package overcooked_pkg;
  localparam logic [7:0] KEY_E           = 8'h08;
  localparam logic [7:0] KEY_Q           = 8'h14;
  localparam logic [3:0] TILE_STOVE      = 4'd3;
  localparam logic [2:0] SPRITE_NONE     = 3'd0;
  localparam logic [2:0] SPRITE_ONION    = 3'd3;
  localparam logic [2:0] SPRITE_PLATE    = 3'd4;
  localparam logic [2:0] SPRITE_SOUP     = 3'd5;
  localparam int         DEBOUNCE_FRAMES = 3;

  typedef enum logic [1:0] {EMPTY, COOKING, READY, BURNT} pot_state_t;

  // bit0 = closed to onions, bit1 = soup complete; 2'b10 is never produced
  localparam logic [1:0] POTSTATE_EMPTY   = 2'b00;
  localparam logic [1:0] POTSTATE_COOKING = 2'b01;
  localparam logic [1:0] POTSTATE_DONE    = 2'b11;

  function automatic logic [1:0] pot_state_bits(pot_state_t s);
    case (s)
      COOKING:       return POTSTATE_COOKING;
      READY, BURNT:  return POTSTATE_DONE;
      default:       return POTSTATE_EMPTY;
    endcase
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// Frame-rate key debouncer: E/Q counts as an action only after the key has been
// released for DEBOUNCE_FRAMES frames. Shared by the pot and onion trackers.
module key_debouncer
  import overcooked_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] keycode_i,
  output logic       action_o
);
  logic [3:0] cnt_q, cnt_d;
  logic       key_eq;

  assign key_eq   = (keycode_i == KEY_E) || (keycode_i == KEY_Q);
  assign action_o = key_eq && (cnt_q >= 4'(DEBOUNCE_FRAMES));

  always_comb begin
    cnt_d = cnt_q;
    if (!key_eq) begin
      if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
    end else if (action_o) begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pot_controller.sv
// Stove pot: collects chopped onions, cooks, holds the soup until plated or
// burnt, and reports state to the onion tracker. One vsync-rate clock.
module pot_controller
  import overcooked_pkg::*;
#(
  parameter int ONIONS_PER_SOUP = 3,
  parameter int COOK_FRAMES     = 300,
  parameter int BURN_FRAMES     = 600,
  parameter int COUNT_BITS      = 10
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [7:0]            keycode,
  input  logic                  wallFlag,
  input  logic [3:0]            tileType,
  input  logic [2:0]            heldSpriteIndexIn,
  input  logic                  onionChopped,
  output logic [1:0]            potState,
  output logic                  potOnionPresent,
  output logic [1:0]            onionCount,
  output logic [COUNT_BITS-1:0] cookTimer,
  output logic                  potBurnt,
  output logic [2:0]            heldSpriteIndexOut,
  output logic                  heldUpdate
);
  pot_state_t            state_q, state_d;
  logic [1:0]            count_q, count_d;
  logic [COUNT_BITS-1:0] timer_q, timer_d;
  logic                  burnt_q, burnt_d;
  logic [2:0]            held_q, held_d;
  logic                  upd_q, upd_d;
  logic                  action, stove_act;

  key_debouncer u_deb (
    .clk_i    (frame_clk),
    .rst_i    (Reset),
    .keycode_i(keycode),
    .action_o (action)
  );

  // Q still consumes the debounce but only E interacts with the stove
  assign stove_act = action && (keycode == KEY_E) && wallFlag && (tileType == TILE_STOVE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    burnt_d = burnt_q;
    held_d  = held_q;
    upd_d   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (stove_act && heldSpriteIndexIn == SPRITE_ONION && onionChopped) begin
          count_d = count_q + 2'd1;
          if (count_d == 2'(ONIONS_PER_SOUP)) begin
            state_d = COOKING;
            timer_d = '0;
          end
        end
      end
      COOKING: begin
        if (timer_q == COUNT_BITS'(COOK_FRAMES - 1)) begin
          state_d = READY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      READY: begin
        timer_d = timer_q + 1'b1;
        // pickup wins over burning on the same frame
        if (stove_act && heldSpriteIndexIn == SPRITE_PLATE) begin
          held_d  = SPRITE_SOUP;
          upd_d   = 1'b1;
          state_d = EMPTY;
          count_d = 2'd0;
          timer_d = '0;
        end else if (timer_q == COUNT_BITS'(BURN_FRAMES - 1)) begin
          state_d = BURNT;
          burnt_d = 1'b1;
        end
      end
      BURNT: begin
        if (stove_act && heldSpriteIndexIn == SPRITE_NONE) begin
          state_d = EMPTY;
          count_d = 2'd0;
          timer_d = '0;
          burnt_d = 1'b0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= EMPTY;
      count_q <= 2'd0;
      timer_q <= '0;
      burnt_q <= 1'b0;
      held_q  <= SPRITE_NONE;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      burnt_q <= burnt_d;
      held_q  <= held_d;
      upd_q   <= upd_d;
    end
  end

  assign potState           = pot_state_bits(state_q);
  assign potOnionPresent    = (count_q != 2'd0);
  assign onionCount         = count_q;
  assign cookTimer          = timer_q;
  assign potBurnt           = burnt_q;
  assign heldSpriteIndexOut = held_q;
  assign heldUpdate         = upd_q;
endmodule

// File: tb/tb_pot_controller.sv
// Scoreboard bench for pot_controller: a frame-level reference model predicts
// outputs for each driven frame; a monitor compares after every clock edge.
module tb_pot_controller;
  localparam int OPS  = 3;
  localparam int COOK = 300;
  localparam int BURN = 600;
  localparam int CB   = 10;

  logic          frame_clk = 1'b0;
  logic          Reset = 1'b0;
  logic [7:0]    keycode = 8'h00;
  logic          wallFlag = 1'b0;
  logic [3:0]    tileType = 4'd0;
  logic [2:0]    heldSpriteIndexIn = 3'd0;
  logic          onionChopped = 1'b0;
  logic [1:0]    potState;
  logic          potOnionPresent;
  logic [1:0]    onionCount;
  logic [CB-1:0] cookTimer;
  logic          potBurnt;
  logic [2:0]    heldSpriteIndexOut;
  logic          heldUpdate;

  pot_controller #(.ONIONS_PER_SOUP(OPS), .COOK_FRAMES(COOK), .BURN_FRAMES(BURN),
                   .COUNT_BITS(CB)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .wallFlag(wallFlag),
    .tileType(tileType), .heldSpriteIndexIn(heldSpriteIndexIn), .onionChopped(onionChopped),
    .potState(potState), .potOnionPresent(potOnionPresent), .onionCount(onionCount),
    .cookTimer(cookTimer), .potBurnt(potBurnt), .heldSpriteIndexOut(heldSpriteIndexOut),
    .heldUpdate(heldUpdate)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int st; int pres; int cnt; int tmr; int burnt; int hout; int hupd; bit tchk;
  } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  // reference model: phase 0 empty, 1 cooking, 2 ready, 3 burnt
  int m_db = 0, m_phase = 0, m_cnt = 0, m_tmr = 0, m_burnt = 0, m_hout = 0, m_hupd = 0;

  task automatic model_step(input bit rst, input int key, input bit wall, input int tile,
                            input int held, input bit chop);
    bit isk, act, stove;
    if (rst) begin
      m_db = 0; m_phase = 0; m_cnt = 0; m_tmr = 0; m_burnt = 0; m_hout = 0; m_hupd = 0;
      return;
    end
    isk = (key == 8'h08) || (key == 8'h14);
    act = 0;
    if (!isk) m_db = (m_db < 15) ? m_db + 1 : 15;
    else if (m_db >= 3) begin act = 1; m_db = 0; end
    stove = act && key == 8'h08 && wall && tile == 3;
    m_hupd = 0;
    if (m_phase == 0) begin
      if (stove && held == 3 && chop) begin
        m_cnt++;
        if (m_cnt == OPS) begin m_phase = 1; m_tmr = 0; end
      end
    end else if (m_phase == 1) begin
      if (m_tmr == COOK - 1) begin m_phase = 2; m_tmr = 0; end
      else m_tmr++;
    end else if (m_phase == 2) begin
      if (stove && held == 4) begin
        m_hout = 5; m_hupd = 1; m_phase = 0; m_cnt = 0; m_tmr = 0;
      end else begin
        if (m_tmr == BURN - 1) begin m_phase = 3; m_burnt = 1; end
        m_tmr++;
      end
    end else begin
      if (stove && held == 0) begin m_phase = 0; m_cnt = 0; m_tmr = 0; m_burnt = 0; end
    end
  endtask

  task automatic frame(input int key, input bit wall = 1, input int tile = 3,
                       input int held = 0, input bit chop = 0, input bit rst = 0);
    exp_t e;
    @(negedge frame_clk);
    Reset = rst; keycode = 8'(key); wallFlag = wall; tileType = 4'(tile);
    heldSpriteIndexIn = 3'(held); onionChopped = chop;
    model_step(rst, key, wall, tile, held, chop);
    e.st    = (m_phase == 0) ? 0 : (m_phase == 1) ? 1 : 3;
    e.pres  = (m_cnt != 0);
    e.cnt   = m_cnt;
    e.tmr   = m_tmr;
    e.burnt = m_burnt;
    e.hout  = m_hout;
    e.hupd  = m_hupd;
    e.tchk  = (m_phase != 3);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every registered output is valid one step after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("potState", int'(potState), e.st);
        chk("potOnionPresent", int'(potOnionPresent), e.pres);
        chk("onionCount", int'(onionCount), e.cnt);
        if (e.tchk) chk("cookTimer", int'(cookTimer), e.tmr);
        chk("potBurnt", int'(potBurnt), e.burnt);
        chk("heldSpriteIndexOut", int'(heldSpriteIndexOut), e.hout);
        chk("heldUpdate", int'(heldUpdate), e.hupd);
      end
    end
  end

  task automatic fill_pot();
    for (int i = 0; i < OPS; i++) begin
      idle(4);
      frame(8'h08, 1, 3, 3, 1);
    end
  endtask

  initial begin
    int r, hsel;
    int held_tbl[8] = '{0, 3, 3, 4, 4, 1, 2, 7};
    frame(0, 0, 0, 0, 0, 1);
    frame(0, 0, 0, 0, 0, 1);
    idle(5);
    frame(8'h08, 1, 3, 3, 1);          // first deposit
    frame(8'h08, 1, 3, 3, 1);          // held E: debounce blocks it
    frame(8'h08, 1, 3, 3, 1);
    idle(4);
    frame(8'h08, 1, 3, 3, 0);          // unchopped onion ignored
    idle(4);
    frame(8'h14, 1, 3, 3, 1);          // Q at stove does nothing
    idle(4);
    frame(8'h08, 1, 3, 3, 1);
    idle(4);
    frame(8'h08, 1, 3, 3, 1);          // third: cooking starts
    idle(COOK + 5);
    frame(8'h08, 1, 3, 4, 0);          // plate pickup
    idle(3);
    fill_pot();
    idle(COOK + BURN + 10);
    frame(8'h08, 1, 3, 4, 0);          // plate on burnt pot ignored
    idle(4);
    frame(8'h08, 1, 3, 0, 0);          // dump with empty hands
    idle(3);
    fill_pot();
    idle(150);
    frame(0, 0, 0, 0, 0, 1);           // reset mid-cook
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      hsel = $urandom_range(0, 7);
      frame((r < 5) ? 0 : (r < 8) ? 8'h08 : (r == 8) ? 8'h14 : int'($urandom_range(0, 255)),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) < 7) ? 3 : int'($urandom_range(0, 15)),
            held_tbl[hsel], 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 999) == 0));
    end
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge frame_clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
